// File: rtl/comparator_tree_pkg.sv
// comparator_tree_pkg: shared width default and the (eq, lt) pair passed up the tree.
package comparator_tree_pkg;

    // Default operand width for comparator_tree
    localparam int DEFAULT_WIDTH = 128;

    // Partial comparison result of one operand slice:
    // eq = slices match, lt = op1 slice < op2 slice (unsigned)
    typedef struct packed {
        logic eq;
        logic lt;
    } cmp_t;

endpackage

// File: rtl/comparator_node.sv
// comparator_node: merges the results of two adjacent slices into the result of the
// combined slice. hi is the more-significant half; it decides unless it is equal.
module comparator_node
    import comparator_tree_pkg::*;
(
    input  cmp_t hi,
    input  cmp_t lo,
    output cmp_t res
);

    assign res.eq = hi.eq & lo.eq;
    assign res.lt = hi.lt | (hi.eq & lo.lt);

endmodule

// File: rtl/comparator_tree.sv
// comparator_tree: equality, signed and unsigned less-than of two WIDTH-bit operands,
// built as a balanced binary tree of comparator_node instances.
// Optional macro COMPARATOR_TREE_OUTREG_EN registers EQ/LT/LTu (1-cycle latency,
// asynchronous clear on reset). Without it the block is purely combinational and
// clk/reset are unused.
// WIDTH must be a power of two in 2..256.
module comparator_tree
    import comparator_tree_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             EQ,
    output logic             LT,
    output logic             LTu
);

    localparam int LEVELS = $clog2(WIDTH);

    // Level LEVELS holds one leaf per bit; level 0 holds the single root.
    // Element j of level lv covers bits [(j+1)*WIDTH/2^lv - 1 : j*WIDTH/2^lv].
    for (genvar lv = 0; lv <= LEVELS; lv++) begin : g_level
        cmp_t lvl [1 << lv];

        if (lv == LEVELS) begin : g_leaf
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                assign lvl[i].eq = ~(op1[i] ^ op2[i]);
                assign lvl[i].lt = ~op1[i] & op2[i];
            end
        end else begin : g_nodes
            for (genvar j = 0; j < (1 << lv); j++) begin : g_node
                comparator_node u_node (
                    .hi  (g_level[lv+1].lvl[2*j+1]),
                    .lo  (g_level[lv+1].lvl[2*j]),
                    .res (lvl[j])
                );
            end
        end
    end

    cmp_t root;
    logic msb1;
    logic msb2;
    logic eq_c;
    logic lt_c;
    logic ltu_c;

    assign root  = g_level[0].lvl[0];
    assign msb1  = op1[WIDTH-1];
    assign msb2  = op2[WIDTH-1];
    assign eq_c  = root.eq;
    assign ltu_c = root.lt;
    // Sign bits differ: the negative operand is smaller. Sign bits equal: the
    // unsigned ordering of the full words equals the signed ordering.
    assign lt_c  = (msb1 & ~msb2) | (~(msb1 ^ msb2) & ltu_c);

`ifdef COMPARATOR_TREE_OUTREG_EN
    // Output register: cleared asynchronously by reset, otherwise loads the tree result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            EQ  <= 1'b0;
            LT  <= 1'b0;
            LTu <= 1'b0;
        end else begin
            EQ  <= eq_c;
            LT  <= lt_c;
            LTu <= ltu_c;
        end
    end
`else
    // clk and reset stay on the port list for a uniform interface but carry no logic here
    logic unused_ctrl;
    assign unused_ctrl = clk ^ reset;

    assign EQ  = eq_c;
    assign LT  = lt_c;
    assign LTu = ltu_c;
`endif

endmodule

// File: tb/tb_comparator_tree.sv
// tb_comparator_tree: randomized and directed checks of comparator_tree (WIDTH=128)
// against a reference built from plain SystemVerilog relational operators.
// Works in both builds; define COMPARATOR_TREE_OUTREG_EN for the registered one.
module tb_comparator_tree;

    localparam int W = 128;

    logic         clk;
    logic         reset;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic         EQ;
    logic         LT;
    logic         LTu;

    int tests;
    int fails;

    comparator_tree #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .op1   (op1),
        .op2   (op2),
        .EQ    (EQ),
        .LT    (LT),
        .LTu   (LTu)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result packed as {EQ, LT, LTu}
    function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        sa = a;
        sb = b;
        return {a == b, sa < sb, a < b};
    endfunction

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got {EQ,LT,LTu}=%b expected %b (op1=%h op2=%h)",
                     tag, got, exp, op1, op2);
        end
    endtask

    // Drive operands and wait until the DUT result for them is observable
    task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b);
        op1 = a;
        op2 = b;
`ifdef COMPARATOR_TREE_OUTREG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        apply(a, b);
        check(tag, {EQ, LT, LTu}, model(a, b));
    endtask

    function automatic logic [W-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [W-1:0] ones;
    logic [W-1:0] a;
    logic [W-1:0] b;

    // Main stimulus sequence
    initial begin
        tests = 0;
        fails = 0;
        ones  = '1;
        op1   = '0;
        op2   = '0;
        reset = 1'b1;

        // Reset state
        #2;
`ifdef COMPARATOR_TREE_OUTREG_EN
        check("reset_state", {EQ, LT, LTu}, 3'b000);
        @(posedge clk);
        #1;
        check("reset_held_over_edge", {EQ, LT, LTu}, 3'b000);
`else
        check("reset_ignored", {EQ, LT, LTu}, 3'b100);
`endif
        @(negedge clk);
        reset = 1'b0;

        // Directed boundary cases, with literal expectations as well as model checks
        apply('0, '0);
        check("zero_zero", {EQ, LT, LTu}, 3'b100);
        apply({1'b0, {(W-1){1'b1}}}, {1'b1, {(W-1){1'b0}}});
        check("maxpos_vs_minneg", {EQ, LT, LTu}, 3'b001);
        apply(ones, W'(1));
        check("minus1_vs_1", {EQ, LT, LTu}, 3'b010);
        a = rnd_word();
        apply({a[W-1:1], 1'b0}, {a[W-1:1], 1'b1});
        check("bit0_lower", {EQ, LT, LTu}, 3'b011);
        apply({a[W-1:1], 1'b1}, {a[W-1:1], 1'b0});
        check("bit0_higher", {EQ, LT, LTu}, 3'b000);
        run("equal_ones", ones, ones);
        run("ones_vs_zero", ones, '0);
        run("zero_vs_ones", '0, ones);

        // Random pairs; some equal, some differing in one bit, to hit deep tree paths
        for (int n = 0; n < 8192; n++) begin
            a = rnd_word();
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ (W'(1) << $urandom_range(0, W-1));
                default: b = rnd_word();
            endcase
            run("random", a, b);
        end

        // Reset mid-stream while an output is high
        for (int k = 0; k < 2; k++) begin
            if (k == 0) run("pre_reset_eq", '0, '0);
            else        run("pre_reset_lt", '0, W'(1));
            #3;
            reset = 1'b1;
            #1;
`ifdef COMPARATOR_TREE_OUTREG_EN
            check("async_reset_clears", {EQ, LT, LTu}, 3'b000);
            @(posedge clk);
            #1;
            check("reset_holds_zero", {EQ, LT, LTu}, 3'b000);
`else
            check("reset_no_effect", {EQ, LT, LTu}, model(op1, op2));
`endif
            @(negedge clk);
            reset = 1'b0;
            a = rnd_word();
            b = rnd_word();
            run("after_release", a, b);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
